// File: rtl/mem_stage_pkg.sv
// Shared memory-op encodings, FSM states and store/alignment helpers for the MEM stage.
package mem_stage_pkg;

    localparam int unsigned RegWidth     = 32;
    localparam int unsigned RegAddrWidth = 5;

    typedef enum logic [3:0] {
        MEM_OP_NONE  = 4'd0,
        MEM_OP_LD_B  = 4'd1,
        MEM_OP_LD_H  = 4'd2,
        MEM_OP_LD_W  = 4'd3,
        MEM_OP_LD_BU = 4'd4,
        MEM_OP_LD_HU = 4'd5,
        MEM_OP_ST_B  = 4'd6,
        MEM_OP_ST_H  = 4'd7,
        MEM_OP_ST_W  = 4'd8
    } mem_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_DATA
    } mem_state_e;

    function automatic logic is_mem_op(input mem_op_e op);
        case (op)
            MEM_OP_LD_B, MEM_OP_LD_H, MEM_OP_LD_W, MEM_OP_LD_BU, MEM_OP_LD_HU,
            MEM_OP_ST_B, MEM_OP_ST_H, MEM_OP_ST_W: is_mem_op = 1'b1;
            default:                               is_mem_op = 1'b0;
        endcase
    endfunction

    function automatic logic is_store_op(input mem_op_e op);
        is_store_op = (op == MEM_OP_ST_B) || (op == MEM_OP_ST_H) || (op == MEM_OP_ST_W);
    endfunction

    function automatic logic is_misaligned(input mem_op_e op, input logic [1:0] lo);
        case (op)
            MEM_OP_LD_H, MEM_OP_LD_HU, MEM_OP_ST_H: is_misaligned = lo[0];
            MEM_OP_LD_W, MEM_OP_ST_W:               is_misaligned = (lo != 2'b00);
            default:                                is_misaligned = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] store_strb(input mem_op_e op, input logic [1:0] lo);
        case (op)
            MEM_OP_ST_B: store_strb = 4'b0001 << lo;
            MEM_OP_ST_H: store_strb = 4'b0011 << lo;
            MEM_OP_ST_W: store_strb = 4'b1111;
            default:     store_strb = '0;
        endcase
    endfunction

    function automatic logic [RegWidth-1:0] store_wdata(input mem_op_e op,
                                                         input logic [RegWidth-1:0] d);
        case (op)
            MEM_OP_ST_B: store_wdata = {4{d[7:0]}};
            MEM_OP_ST_H: store_wdata = {2{d[15:0]}};
            MEM_OP_ST_W: store_wdata = d;
            default:     store_wdata = '0;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data alignment: picks the addressed byte/half out of the bus word and extends it.
module mem_load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [3:0]  mem_op_i,
    output logic [31:0] data_o
);

    logic [31:0] shifted;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign shifted  = rdata_i >> {addr_lo_i, 3'b000};
    assign byte_sel = shifted[7:0];
    assign half_sel = shifted[15:0];

    always_comb begin
        data_o = rdata_i;
        case (mem_op_e'(mem_op_i))
            MEM_OP_LD_B:  data_o = {{24{byte_sel[7]}}, byte_sel};
            MEM_OP_LD_BU: data_o = {24'd0, byte_sel};
            MEM_OP_LD_H:  data_o = {{16{half_sel[15]}}, half_sel};
            MEM_OP_LD_HU: data_o = {16'd0, half_sel};
            default:      data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: registers EX results, runs loads/stores on an addr_ok/data_ok bus,
// and presents one registered result per instruction to write-back.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [3:0]            mem_op_i,
    input  logic [REG_ADDR_W-1:0] reg_write_addr_i,
    input  logic                  reg_write_en_i,
    input  logic [DATA_W-1:0]     reg_write_data_i,
    input  logic [DATA_W-1:0]     store_data_i,
    output logic                  data_req_o,
    output logic                  data_wr_o,
    output logic [3:0]            data_wstrb_o,
    output logic [ADDR_W-1:0]     data_addr_o,
    output logic [DATA_W-1:0]     data_wdata_o,
    input  logic                  data_addr_ok_i,
    input  logic                  data_data_ok_i,
    input  logic [DATA_W-1:0]     data_rdata_i,
    output logic                  wb_valid_o,
    input  logic                  wb_ready_i,
    output logic [REG_ADDR_W-1:0] wb_reg_addr_o,
    output logic                  wb_reg_en_o,
    output logic [DATA_W-1:0]     wb_reg_data_o,
    output logic                  ale_o
);

    mem_state_e            state_q, state_n;
    mem_op_e               op_in, op_q;
    logic [1:0]            addr_lo_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic                  rd_en_q;
    logic                  kill_q;

    logic                  wb_free, accept, in_is_mem, in_mis, start_bus;
    logic                  bus_done, capture_mem;
    logic [DATA_W-1:0]     load_data;

    assign op_in     = mem_op_e'(mem_op_i);
    assign in_is_mem = is_mem_op(op_in);
    assign in_mis    = is_misaligned(op_in, reg_write_data_i[1:0]);

    assign wb_free    = !wb_valid_o || wb_ready_i;
    assign in_ready_o = (state_q == ST_IDLE) && wb_free;
    assign accept     = in_valid_i && in_ready_o && !flush_i;
    assign start_bus  = accept && in_is_mem && !in_mis;

    assign bus_done    = data_data_ok_i &&
                         ((state_q == ST_WAIT_DATA) || (state_q == ST_REQ && data_addr_ok_i));
    // A flushed instruction still drains its bus response; kill_q just drops the result.
    assign capture_mem = bus_done && !kill_q && !flush_i;

    assign data_req_o = (state_q == ST_REQ);

    mem_load_align u_load_align (
        .rdata_i   (data_rdata_i),
        .addr_lo_i (addr_lo_q),
        .mem_op_i  (op_q),
        .data_o    (load_data)
    );

    always_comb begin
        state_n = state_q;
        case (state_q)
            ST_IDLE:      if (start_bus) state_n = ST_REQ;
            ST_REQ:       if (data_addr_ok_i) state_n = data_data_ok_i ? ST_IDLE : ST_WAIT_DATA;
            ST_WAIT_DATA: if (data_data_ok_i) state_n = ST_IDLE;
            default:      state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            op_q          <= MEM_OP_NONE;
            addr_lo_q     <= '0;
            rd_q          <= '0;
            rd_en_q       <= 1'b0;
            kill_q        <= 1'b0;
            data_wr_o     <= 1'b0;
            data_wstrb_o  <= '0;
            data_addr_o   <= '0;
            data_wdata_o  <= '0;
            wb_valid_o    <= 1'b0;
            wb_reg_addr_o <= '0;
            wb_reg_en_o   <= 1'b0;
            wb_reg_data_o <= '0;
            ale_o         <= 1'b0;
        end else begin
            state_q <= state_n;

            if (state_n == ST_IDLE)
                kill_q <= 1'b0;
            else if (flush_i && state_q != ST_IDLE)
                kill_q <= 1'b1;

            if (start_bus) begin
                op_q         <= op_in;
                addr_lo_q    <= reg_write_data_i[1:0];
                rd_q         <= reg_write_addr_i;
                rd_en_q      <= reg_write_en_i;
                data_wr_o    <= is_store_op(op_in);
                data_wstrb_o <= store_strb(op_in, reg_write_data_i[1:0]);
                data_addr_o  <= {reg_write_data_i[ADDR_W-1:2], 2'b00};
                data_wdata_o <= store_wdata(op_in, store_data_i);
            end

            if (flush_i) begin
                wb_valid_o <= 1'b0;
            end else if (accept && !in_is_mem) begin
                wb_valid_o    <= 1'b1;
                wb_reg_addr_o <= reg_write_addr_i;
                wb_reg_en_o   <= reg_write_en_i;
                wb_reg_data_o <= reg_write_data_i;
                ale_o         <= 1'b0;
            end else if (accept && in_mis) begin
                wb_valid_o    <= 1'b1;
                wb_reg_addr_o <= reg_write_addr_i;
                wb_reg_en_o   <= 1'b0;
                wb_reg_data_o <= reg_write_data_i;
                ale_o         <= 1'b1;
            end else if (capture_mem) begin
                wb_valid_o    <= 1'b1;
                wb_reg_addr_o <= rd_q;
                wb_reg_en_o   <= rd_en_q && !is_store_op(op_q);
                wb_reg_data_o <= is_store_op(op_q) ? '0 : load_data;
                ale_o         <= 1'b0;
            end else if (wb_ready_i) begin
                wb_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: ALU pass-through, loads, stores, misalignment,
// bus back-pressure, write-back stall, flush and reset.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [3:0]  mem_op_i;
    logic [4:0]  reg_write_addr_i;
    logic        reg_write_en_i;
    logic [31:0] reg_write_data_i;
    logic [31:0] store_data_i;
    logic        data_req_o;
    logic        data_wr_o;
    logic [3:0]  data_wstrb_o;
    logic [31:0] data_addr_o;
    logic [31:0] data_wdata_o;
    logic        data_addr_ok_i;
    logic        data_data_ok_i;
    logic [31:0] data_rdata_i;
    logic        wb_valid_o;
    logic        wb_ready_i;
    logic [4:0]  wb_reg_addr_o;
    logic        wb_reg_en_o;
    logic [31:0] wb_reg_data_o;
    logic        ale_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_stage #(.DATA_W(32), .ADDR_W(32), .REG_ADDR_W(5)) dut (
        .clk              (clk),
        .rst              (rst),
        .flush_i          (flush_i),
        .in_valid_i       (in_valid_i),
        .in_ready_o       (in_ready_o),
        .mem_op_i         (mem_op_i),
        .reg_write_addr_i (reg_write_addr_i),
        .reg_write_en_i   (reg_write_en_i),
        .reg_write_data_i (reg_write_data_i),
        .store_data_i     (store_data_i),
        .data_req_o       (data_req_o),
        .data_wr_o        (data_wr_o),
        .data_wstrb_o     (data_wstrb_o),
        .data_addr_o      (data_addr_o),
        .data_wdata_o     (data_wdata_o),
        .data_addr_ok_i   (data_addr_ok_i),
        .data_data_ok_i   (data_data_ok_i),
        .data_rdata_i     (data_rdata_i),
        .wb_valid_o       (wb_valid_o),
        .wb_ready_i       (wb_ready_i),
        .wb_reg_addr_o    (wb_reg_addr_o),
        .wb_reg_en_o      (wb_reg_en_o),
        .wb_reg_data_o    (wb_reg_data_o),
        .ale_o            (ale_o)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic present(input logic [3:0] op, input logic [4:0] rd, input logic [31:0] d,
                           input logic [31:0] sd);
        in_valid_i       = 1'b1;
        mem_op_i         = op;
        reg_write_addr_i = rd;
        reg_write_en_i   = 1'b1;
        reg_write_data_i = d;
        store_data_i     = sd;
    endtask

    initial begin
        rst = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; mem_op_i = '0;
        reg_write_addr_i = '0; reg_write_en_i = 1'b0; reg_write_data_i = '0; store_data_i = '0;
        data_addr_ok_i = 1'b0; data_data_ok_i = 1'b0; data_rdata_i = '0; wb_ready_i = 1'b1;
        step(); step();

        chk("rst_in_ready", in_ready_o, 1);
        chk("rst_req", data_req_o, 0);
        chk("rst_wr", data_wr_o, 0);
        chk("rst_wstrb", data_wstrb_o, 0);
        chk("rst_addr", data_addr_o, 0);
        chk("rst_wdata", data_wdata_o, 0);
        chk("rst_wb_valid", wb_valid_o, 0);
        chk("rst_wb_addr", wb_reg_addr_o, 0);
        chk("rst_wb_en", wb_reg_en_o, 0);
        chk("rst_wb_data", wb_reg_data_o, 0);
        chk("rst_ale", ale_o, 0);
        rst = 1'b0;
        step();

        // ALU op: one-cycle latency, no bus activity
        present(MEM_OP_NONE, 5'd5, 32'h1234_5678, 32'h0);
        step();
        in_valid_i = 1'b0;
        chk("alu_valid", wb_valid_o, 1);
        chk("alu_data", wb_reg_data_o, 32'h1234_5678);
        chk("alu_en", wb_reg_en_o, 1);
        chk("alu_rd", wb_reg_addr_o, 5);
        chk("alu_req", data_req_o, 0);
        chk("alu_ale", ale_o, 0);
        step();
        chk("alu_clear", wb_valid_o, 0);

        // ld.b 0x1003: accept, req, addr_ok, data_ok, result
        present(MEM_OP_LD_B, 5'd6, 32'h0000_1003, 32'h0);
        step();
        in_valid_i = 1'b0;
        #1;
        chk("ldb_req", data_req_o, 1);
        chk("ldb_addr", data_addr_o, 32'h0000_1000);
        chk("ldb_wr", data_wr_o, 0);
        chk("ldb_in_ready", in_ready_o, 0);
        data_addr_ok_i = 1'b1;
        step();
        data_addr_ok_i = 1'b0;
        chk("ldb_req_drop", data_req_o, 0);
        chk("ldb_wait_valid", wb_valid_o, 0);
        data_data_ok_i = 1'b1; data_rdata_i = 32'h80FF_0000;
        step();
        data_data_ok_i = 1'b0;
        chk("ldb_valid", wb_valid_o, 1);
        chk("ldb_data", wb_reg_data_o, 32'hFFFF_FF80);
        chk("ldb_en", wb_reg_en_o, 1);
        chk("ldb_rd", wb_reg_addr_o, 6);

        // ld.bu 0x1003 with addr_ok and data_ok in the same cycle
        present(MEM_OP_LD_BU, 5'd7, 32'h0000_1003, 32'h0);
        step();
        in_valid_i = 1'b0;
        chk("ldbu_req", data_req_o, 1);
        data_addr_ok_i = 1'b1; data_data_ok_i = 1'b1; data_rdata_i = 32'h80FF_0000;
        step();
        data_addr_ok_i = 1'b0; data_data_ok_i = 1'b0;
        chk("ldbu_valid", wb_valid_o, 1);
        chk("ldbu_data", wb_reg_data_o, 32'h0000_0080);
        chk("ldbu_in_ready", in_ready_o, 1);

        // ld.h 0x1002 sign-extends upper half
        present(MEM_OP_LD_H, 5'd8, 32'h0000_1002, 32'h0);
        step();
        in_valid_i = 1'b0;
        data_addr_ok_i = 1'b1; data_data_ok_i = 1'b1; data_rdata_i = 32'h80FF_0000;
        step();
        data_addr_ok_i = 1'b0; data_data_ok_i = 1'b0;
        chk("ldh_data", wb_reg_data_o, 32'hFFFF_80FF);

        // st.h 0x2002 data 0xABCD
        present(MEM_OP_ST_H, 5'd7, 32'h0000_2002, 32'h0000_ABCD);
        step();
        in_valid_i = 1'b0;
        chk("sth_req", data_req_o, 1);
        chk("sth_wr", data_wr_o, 1);
        chk("sth_wstrb", data_wstrb_o, 4'b1100);
        chk("sth_wdata", data_wdata_o, 32'hABCD_ABCD);
        chk("sth_addr", data_addr_o, 32'h0000_2000);
        data_addr_ok_i = 1'b1;
        step();
        data_addr_ok_i = 1'b0; data_data_ok_i = 1'b1;
        step();
        data_data_ok_i = 1'b0;
        chk("sth_valid", wb_valid_o, 1);
        chk("sth_en", wb_reg_en_o, 0);

        // st.b 0x2001 data 0x5A
        present(MEM_OP_ST_B, 5'd3, 32'h0000_2001, 32'h1234_565A);
        step();
        in_valid_i = 1'b0;
        chk("stb_wstrb", data_wstrb_o, 4'b0010);
        chk("stb_wdata", data_wdata_o, 32'h5A5A_5A5A);
        data_addr_ok_i = 1'b1; data_data_ok_i = 1'b1;
        step();
        data_addr_ok_i = 1'b0; data_data_ok_i = 1'b0;

        // ld.w 0x3001 misaligned: no request, ale result next cycle
        present(MEM_OP_LD_W, 5'd9, 32'h0000_3001, 32'h0);
        step();
        in_valid_i = 1'b0;
        chk("ale_req", data_req_o, 0);
        chk("ale_valid", wb_valid_o, 1);
        chk("ale_flag", ale_o, 1);
        chk("ale_en", wb_reg_en_o, 0);
        step();
        chk("ale_no_req", data_req_o, 0);

        // ld.w with delayed addr_ok, late data_ok, write-back stalled two cycles
        present(MEM_OP_LD_W, 5'd10, 32'h0000_4000, 32'h0);
        step();
        present(MEM_OP_NONE, 5'd11, 32'h5555_5555, 32'h0);
        #1;
        chk("slow_req1", data_req_o, 1);
        chk("slow_in_ready1", in_ready_o, 0);
        step();
        chk("slow_req2", data_req_o, 1);
        step();
        chk("slow_req3", data_req_o, 1);
        chk("slow_in_ready3", in_ready_o, 0);
        data_addr_ok_i = 1'b1;
        step();
        data_addr_ok_i = 1'b0;
        in_valid_i = 1'b0;
        chk("slow_req_drop", data_req_o, 0);
        step();
        wb_ready_i = 1'b0;
        data_data_ok_i = 1'b1; data_rdata_i = 32'hDEAD_BEEF;
        step();
        data_data_ok_i = 1'b0; data_rdata_i = 32'h0;
        chk("slow_valid", wb_valid_o, 1);
        chk("slow_data", wb_reg_data_o, 32'hDEAD_BEEF);
        chk("slow_rd", wb_reg_addr_o, 10);
        chk("slow_in_ready_stall", in_ready_o, 0);
        step();
        chk("slow_hold_valid", wb_valid_o, 1);
        chk("slow_hold_data", wb_reg_data_o, 32'hDEAD_BEEF);
        wb_ready_i = 1'b1;
        #1;
        chk("slow_in_ready_go", in_ready_o, 1);
        step();
        chk("slow_drain", wb_valid_o, 0);

        // flush while waiting for data: response consumed, no result
        present(MEM_OP_LD_W, 5'd12, 32'h0000_5000, 32'h0);
        step();
        in_valid_i = 1'b0;
        data_addr_ok_i = 1'b1;
        step();
        data_addr_ok_i = 1'b0;
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        chk("flush_wait_ready", in_ready_o, 0);
        data_data_ok_i = 1'b1; data_rdata_i = 32'h1111_1111;
        step();
        data_data_ok_i = 1'b0;
        chk("flush_valid", wb_valid_o, 0);
        chk("flush_in_ready", in_ready_o, 1);

        // flush in IDLE blocks accept
        present(MEM_OP_NONE, 5'd13, 32'hCAFE_0000, 32'h0);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0; in_valid_i = 1'b0;
        chk("flush_idle_valid", wb_valid_o, 0);

        // reset mid-transaction
        present(MEM_OP_LD_W, 5'd14, 32'h0000_6000, 32'h0);
        step();
        in_valid_i = 1'b0;
        chk("rstmid_req", data_req_o, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstmid_req_off", data_req_o, 0);
        chk("rstmid_in_ready", in_ready_o, 1);
        chk("rstmid_addr", data_addr_o, 0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
